// File: rtl/la_word_serializer_if.sv
// la_word_serializer_if: word input handshake and paced serial output of the word serializer
interface la_word_serializer_if #(parameter int WIDTH = 128, parameter int DEPTH = 2);
  logic [WIDTH-1:0] in_data;
  logic in_valid;
  logic in_ready;
  logic ser_en;
  logic ser_out;
  logic ser_frame;
  logic [$clog2(DEPTH+1)-1:0] fifo_level;
  modport master (output in_data, in_valid, ser_en, input in_ready, ser_out, ser_frame, fifo_level);
  modport slave (input in_data, in_valid, ser_en, output in_ready, ser_out, ser_frame, fifo_level);
endinterface

// File: rtl/la_word_serializer.sv
// la_word_serializer: FIFO-buffered wide words returned as a framed MSB-first serial stream
module la_word_serializer #(parameter int WIDTH = 128, parameter int DEPTH = 2) (
  input logic wb_clk_i,
  input logic wb_rst_i,
  la_word_serializer_if.slave bus
);
  localparam int LW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [LW-1:0] level_q, level_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic has, adv, last, push, pop;
  assign bus.in_ready = level_q < LW'(DEPTH);
  assign bus.ser_frame = state_q == SHIFT;
  assign bus.ser_out = bus.ser_frame && shreg_q[WIDTH-1];
  assign bus.fifo_level = level_q;
  always_comb begin
    has = level_q != '0;
    adv = state_q == SHIFT && bus.ser_en;
    last = cnt_q == CW'(WIDTH-1);
    push = bus.in_valid && bus.in_ready;
    pop = has && (state_q == IDLE || (adv && last));
    state_d = state_q == IDLE ? (has ? SHIFT : IDLE) : (adv && last && !has ? IDLE : SHIFT);
    level_d = level_q + LW'(push) - LW'(pop);
    shreg_d = pop ? mem_q[rptr_q] : adv ? shreg_q << 1 : shreg_q;
    cnt_d = pop ? '0 : (adv && !last) ? cnt_q + CW'(1) : cnt_q;
  end
  // storage needs no reset: pointers and level define which entries are live
  always_ff @(posedge wb_clk_i) begin
    if (push) mem_q[wptr_q] <= bus.in_data;
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      wptr_q <= '0;
      rptr_q <= '0;
      level_q <= '0;
      shreg_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      wptr_q <= push ? wptr_q + PW'(1) : wptr_q;
      rptr_q <= pop ? rptr_q + PW'(1) : rptr_q;
      level_q <= level_d;
      shreg_q <= shreg_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_la_word_serializer.sv
// tb_la_word_serializer: scoreboard bench, accepted words queued and rebuilt from the serial stream
module tb_la_word_serializer;
  localparam int W = 128;
  localparam int D = 2;
  logic wb_clk_i = 0;
  logic wb_rst_i = 1;
  la_word_serializer_if #(.WIDTH(W), .DEPTH(D)) bus();
  la_word_serializer #(.WIDTH(W), .DEPTH(D)) dut (.wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .bus(bus));
  always #5 wb_clk_i = ~wb_clk_i;
  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q [$];
  int accepted = 0;
  int completed = 0;
  int nbits = 0;
  logic [W-1:0] cur = '0;
  logic last_acc, s_frame, s_ready, s_out;
  int s_level;
  int fcount = 0;
  int fstarts = 0;
  int ready_lows = 0;
  logic prev_frame = 0;
  logic toggle_en = 0;
  logic rand_en = 0;
  function void chk(input string n, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, req);
    end
  endfunction
  function void chkw(input string n, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, req);
    end
  endfunction
  function logic [W-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  always @(negedge wb_clk_i) begin
    if (wb_rst_i) begin
      nbits = 0;
      completed = 0;
    end else begin
      chk("fifo_level", int'(bus.fifo_level), accepted - completed - int'(bus.ser_frame));
      chk("in_ready", int'(bus.in_ready), int'(accepted - completed - int'(bus.ser_frame) < D));
      if (!bus.ser_frame) chk("idle_ser_out", int'(bus.ser_out), 0);
      else if (bus.ser_en) begin
        cur = {cur[W-2:0], bus.ser_out};
        nbits++;
        if (nbits == W) begin
          nbits = 0;
          completed++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got %h expected none", cur);
          end else chkw("word", cur, exp_q.pop_front());
        end
      end
    end
  end
  task automatic cyc();
    @(negedge wb_clk_i);
    s_frame = bus.ser_frame;
    s_ready = bus.in_ready;
    s_out = bus.ser_out;
    s_level = int'(bus.fifo_level);
    last_acc = bus.in_valid && bus.in_ready;
    if (s_frame) fcount++;
    if (s_frame && !prev_frame) fstarts++;
    if (!s_ready) ready_lows++;
    prev_frame = s_frame;
    @(posedge wb_clk_i);
    #1;
    if (last_acc && !wb_rst_i) begin
      exp_q.push_back(bus.in_data);
      accepted++;
    end
    if (toggle_en) bus.ser_en = ~bus.ser_en;
    else if (rand_en) bus.ser_en = $urandom_range(3) != 0;
  endtask
  task automatic push_word(input logic [W-1:0] w, input bit rv);
    int n = 0;
    bus.in_data = w;
    do begin
      bus.in_valid = rv ? ($urandom_range(1) == 1) : 1'b1;
      cyc();
      n++;
    end while (!last_acc && n < 5000);
    bus.in_valid = 0;
    chk("push_accept", int'(last_acc), 1);
  endtask
  task automatic wait_frame();
    int n = 0;
    do begin
      cyc();
      n++;
    end while (!s_frame && n < 1000);
    chk("frame_start", int'(s_frame), 1);
  endtask
  task automatic drain();
    int n = 0;
    do begin
      cyc();
      n++;
    end while ((exp_q.size() != 0 || s_frame) && n < 40000);
    chk("drain_queue", exp_q.size(), 0);
    chk("drain_frame", int'(s_frame), 0);
  endtask
  task automatic clr();
    fcount = 0;
    fstarts = 0;
    ready_lows = 0;
  endtask
  initial begin
    int n_acc;
    logic [W-1:0] w;
    bus.in_data = '0;
    bus.in_valid = 0;
    bus.ser_en = 1;
    repeat (2) cyc();
    wb_rst_i = 0;
    cyc();
    chk("rst_frame", int'(s_frame), 0);
    chk("rst_out", int'(s_out), 0);
    chk("rst_level", s_level, 0);
    chk("rst_ready", int'(s_ready), 1);
    clr();
    w = '0;
    w[W-1] = 1'b1;
    w[0] = 1'b1;
    push_word(w, 0);
    cyc();
    chk("t1_not_yet", int'(s_frame), 0);
    chk("t1_level_one", s_level, 1);
    cyc();
    chk("t1_frame_up", int'(s_frame), 1);
    chk("t1_msb", int'(s_out), 1);
    chk("t1_level_zero", s_level, 0);
    drain();
    chk("t1_frame_len", fcount, 128);
    chk("t1_frames", fstarts, 1);
    clr();
    repeat (3) push_word(rnd(), 0);
    drain();
    chk("t2_frame_len", fcount, 384);
    chk("t2_contiguous", fstarts, 1);
    chk("t2_backpressure", int'(ready_lows != 0), 1);
    clr();
    bus.ser_en = 0;
    push_word({16{8'hA5}}, 0);
    wait_frame();
    bus.ser_en = 1;
    toggle_en = 1;
    drain();
    toggle_en = 0;
    bus.ser_en = 1;
    chk("t3_frame_len", fcount, 256);
    chk("t3_frames", fstarts, 1);
    repeat (3) push_word(rnd(), 0);
    repeat (37) cyc();
    wb_rst_i = 1;
    exp_q.delete();
    accepted = 0;
    cyc();
    wb_rst_i = 0;
    cyc();
    chk("t4_frame", int'(s_frame), 0);
    chk("t4_out", int'(s_out), 0);
    chk("t4_level", s_level, 0);
    chk("t4_ready", int'(s_ready), 1);
    clr();
    repeat (300) cyc();
    chk("t4_silent", fcount, 0);
    bus.ser_en = 0;
    n_acc = 0;
    bus.in_data = rnd();
    bus.in_valid = 1;
    repeat (10) begin
      cyc();
      if (last_acc) begin
        n_acc++;
        bus.in_data = rnd();
      end
    end
    bus.in_valid = 0;
    chk("t5_accepted", n_acc, 3);
    chk("t5_level", s_level, 2);
    chk("t5_ready", int'(s_ready), 0);
    bus.ser_en = 1;
    drain();
    rand_en = 1;
    repeat (200) push_word(rnd(), 1);
    rand_en = 0;
    bus.ser_en = 1;
    drain();
    chk("t6_words", completed, accepted);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #700000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
